// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle CPU control FSM with memory-wait timeout and sticky fault state.
module mc_control_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] State,
  output logic       Fault
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, JAL = 4'd9, EXECI = 4'd10, ERROR = 4'd11
  } state_t;
  state_t state, nxt;
  logic [7:0] cnt, cnt_nxt;
  logic wait_st, wait_nxt, timeout;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      cnt   <= 8'd0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  always_comb begin
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 2'b00;
    PCSource = 2'b00;
    ALUSrcA = 2'b00;
    ALUSrcB = 2'b00;
    ALUOp = 2'b00;
    Fault = 1'b0;
    nxt = state;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        nxt = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        nxt = (Opcode == 7'b0000011 || Opcode == 7'b0100011) ? MEMADR :
              (Opcode == 7'b0110011) ? EXEC :
              (Opcode == 7'b0010011) ? EXECI :
              (Opcode == 7'b1100011) ? BRANCH :
              (Opcode == 7'b1101111) ? JAL : ERROR;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b10;
        nxt = (Opcode == 7'b0000011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        nxt = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
        nxt = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
        nxt = MemReady ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA = 2'b10;
        ALUOp = 2'b10;
        nxt = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b10;
        ALUOp = 2'b11;
        nxt = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        nxt = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp = 2'b01;
        PCWriteCond = 1'b1;
        PCSource = 2'b01;
        nxt = FETCH;
      end
      JAL: begin
        PCWrite = 1'b1;
        PCSource = 2'b01;
        RegWrite = 1'b1;
        MemtoReg = 2'b10;
        nxt = FETCH;
      end
      ERROR: begin
        Fault = 1'b1;
        nxt = ERROR;
      end
      default: nxt = ERROR;
    endcase
    if (timeout) nxt = ERROR;
  end
  // A ready memory in the final allowed cycle still completes the access.
  assign wait_st  = state == FETCH || state == MEMRD || state == MEMWR;
  assign wait_nxt = nxt == FETCH || nxt == MEMRD || nxt == MEMWR;
  assign timeout  = wait_st && !MemReady && cnt == 8'(MEM_TIMEOUT - 1);
  assign cnt_nxt  = (wait_nxt && nxt != state) ? 8'd0 : (wait_st && !MemReady) ? cnt + 8'd1 : cnt;
  assign State    = state;
endmodule
